// File: rtl/off_mem_arbiter.sv
// Two-requester arbiter onto a simple dual-port BRAM: port A writes, port B reads (1-cycle latency).
// Optional burst locking is compiled in when OFF_MEM_ARB_LOCK_EN is defined.
module off_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [1:0]            lock_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  wea_o,
    output logic [ADDR_WIDTH-1:0] addra_o,
    output logic [DATA_WIDTH-1:0] dina_o,
    output logic                  enb_o,
    output logic [ADDR_WIDTH-1:0] addrb_o,
    input  logic [DATA_WIDTH-1:0] doutb_i
);

    // Per-port vectors: index 0 is the write port (A), index 1 the read port (B).
    logic [1:0][1:0]       preq;
    logic [1:0]            pref;
    logic [1:0]            win;
    logic [1:0]            pgnt;
    logic                  wr_gnt;
    logic                  rd_gnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign preq[0] = req_i & we_i;
    assign preq[1] = req_i & ~we_i;

`ifdef OFF_MEM_ARB_LOCK_EN
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    logic [1:0]           lk_act_q, lk_act_d;
    logic [1:0]           lk_own_q, lk_own_d;
    logic [1:0][CntW-1:0] lk_cnt_q, lk_cnt_d;
    logic [CntW-1:0]      cnt_n;

    // A live lock overrides the round-robin pointer while its owner keeps requesting locked.
    always_comb begin
        pref = ptr_q;
        for (int p = 0; p < 2; p++) begin
            if (lk_act_q[p] && preq[p][lk_own_q[p]] && lock_i[lk_own_q[p]]) begin
                pref[p] = lk_own_q[p];
            end
        end
    end

    always_comb begin
        lk_act_d = lk_act_q;
        lk_own_d = lk_own_q;
        lk_cnt_d = lk_cnt_q;
        cnt_n    = '0;
        for (int p = 0; p < 2; p++) begin
            cnt_n = CntW'(1);
            if (lk_act_q[p] && (!preq[p][lk_own_q[p]] || !lock_i[lk_own_q[p]])) begin
                lk_act_d[p] = 1'b0;
                lk_cnt_d[p] = '0;
            end
            if (pgnt[p]) begin
                if (lock_i[win[p]]) begin
                    if (lk_act_q[p] && (lk_own_q[p] == win[p])) begin
                        cnt_n = lk_cnt_q[p] + CntW'(1);
                    end
                    lk_own_d[p] = win[p];
                    if (cnt_n < CntW'(LOCK_MAX)) begin
                        lk_act_d[p] = 1'b1;
                        lk_cnt_d[p] = cnt_n;
                    end else begin
                        lk_act_d[p] = 1'b0;
                        lk_cnt_d[p] = '0;
                    end
                end else begin
                    lk_act_d[p] = 1'b0;
                    lk_cnt_d[p] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lk_act_q <= '0;
            lk_own_q <= '0;
            lk_cnt_q <= '0;
        end else begin
            lk_act_q <= lk_act_d;
            lk_own_q <= lk_own_d;
            lk_cnt_q <= lk_cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^{lock_i, 32'(LOCK_MAX)};
    assign pref        = ptr_q;
`endif

    always_comb begin
        win = '0;
        for (int p = 0; p < 2; p++) begin
            win[p] = (preq[p] == 2'b11) ? pref[p] : preq[p][1];
        end
    end

    assign wr_addr = win[0] ? addr1_i : addr0_i;
    assign rd_addr = win[1] ? addr1_i : addr0_i;
    assign wr_gnt  = |preq[0];
    // A read aimed at the address being written waits a cycle so it returns the new data.
    assign rd_gnt  = (|preq[1]) && !(wr_gnt && (wr_addr == rd_addr));
    assign pgnt    = {rd_gnt, wr_gnt};

    assign wea_o   = wr_gnt & reset_n;
    assign enb_o   = rd_gnt & reset_n;
    assign addra_o = wr_addr;
    assign dina_o  = win[0] ? wdata1_i : wdata0_i;
    assign addrb_o = rd_addr;

    always_comb begin
        gnt_o = '0;
        if (wea_o) gnt_o[win[0]] = 1'b1;
        if (enb_o) gnt_o[win[1]] = 1'b1;
    end

    assign ptr_d    = (pgnt & ~win) | (~pgnt & ptr_q);
    assign rvalid_d = enb_o ? (2'b01 << win[1]) : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            if (|rvalid_q) rdata_q <= doutb_i;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = (|rvalid_q) ? doutb_i : rdata_q;

endmodule

// File: tb/tb_off_mem_arbiter.sv
// Scoreboard bench for off_mem_arbiter: driver queues per-cycle and read-response expectations,
// a negedge monitor pops and compares them against a behavioural BRAM-backed DUT.
module tb_off_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    typedef struct packed {
        logic [1:0]    gnt;
        logic          wea;
        logic          enb;
        logic [AW-1:0] addra;
        logic [DW-1:0] dina;
        logic [AW-1:0] addrb;
    } cyc_t;

    typedef struct packed {
        logic [1:0]    rv;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    req_i, we_i, lock_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [DW-1:0] wdata0_i, wdata1_i;
    logic [1:0]    gnt_o, rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          wea_o, enb_o;
    logic [AW-1:0] addra_o, addrb_o;
    logic [DW-1:0] dina_o;
    logic [DW-1:0] doutb;

    int n_chk  = 0;
    int n_fail = 0;

    cyc_t cyc_q[$];
    rsp_t rsp_q[$];
    cyc_t mon_e;
    rsp_t mon_r;

    logic [DW-1:0] mem [256];
    logic [255:0]  written = '0;

    always #5 clk = ~clk;

    off_mem_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LOCK_MAX  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (req_i),
        .we_i    (we_i),
        .lock_i  (lock_i),
        .addr0_i (addr0_i),
        .addr1_i (addr1_i),
        .wdata0_i(wdata0_i),
        .wdata1_i(wdata1_i),
        .gnt_o   (gnt_o),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .wea_o   (wea_o),
        .addra_o (addra_o),
        .dina_o  (dina_o),
        .enb_o   (enb_o),
        .addrb_o (addrb_o),
        .doutb_i (doutb)
    );

    // Unwritten locations read back as C0DE_00xx so reads of them are still predictable.
    always @(posedge clk) begin
        if (wea_o) begin
            mem[addra_o]     <= dina_o;
            written[addra_o] <= 1'b1;
        end
        if (enb_o) doutb <= written[addrb_o] ? mem[addrb_o] : (32'hC0DE_0000 | 32'(addrb_o));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rst_n, input logic [1:0] req, input logic [1:0] we,
                       input logic [1:0] lk, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] exp_gnt, input logic [DW-1:0] rd_data, input bit rsp_en);
        cyc_t       e;
        rsp_t       r;
        logic [1:0] wg, rg;
        @(posedge clk);
        #1;
        reset_n  = rst_n;
        req_i    = req;
        we_i     = we;
        lock_i   = lk;
        addr0_i  = a0;
        addr1_i  = a1;
        wdata0_i = d0;
        wdata1_i = d1;
        wg       = exp_gnt & we;
        rg       = exp_gnt & ~we;
        e.gnt    = exp_gnt;
        e.wea    = |wg;
        e.enb    = |rg;
        e.addra  = wg[1] ? a1 : a0;
        e.dina   = wg[1] ? d1 : d0;
        e.addrb  = rg[1] ? a1 : a0;
        cyc_q.push_back(e);
        if (rsp_en && (|rg)) begin
            r.rv   = rg;
            r.data = rd_data;
            rsp_q.push_back(r);
        end
    endtask

    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_e = cyc_q.pop_front();
            check("gnt", 64'(gnt_o), 64'(mon_e.gnt));
            check("wea", 64'(wea_o), 64'(mon_e.wea));
            check("enb", 64'(enb_o), 64'(mon_e.enb));
            if (mon_e.wea) begin
                check("addra", 64'(addra_o), 64'(mon_e.addra));
                check("dina", 64'(dina_o), 64'(mon_e.dina));
            end
            if (mon_e.enb) check("addrb", 64'(addrb_o), 64'(mon_e.addrb));
        end
        if (rvalid_o != 2'b00) begin
            if (rsp_q.size() == 0) begin
                check("rvalid_unexpected", 64'(rvalid_o), 64'(0));
            end else begin
                mon_r = rsp_q.pop_front();
                check("rvalid", 64'(rvalid_o), 64'(mon_r.rv));
                check("rdata", 64'(rdata_o), 64'(mon_r.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b1;
        req_i    = 2'b11;
        we_i     = 2'b01;
        lock_i   = 2'b00;
        addr0_i  = 8'h03;
        addr1_i  = 8'h04;
        wdata0_i = 32'h1234_5678;
        wdata1_i = 32'h0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(gnt_o), 64'(0));
        check("rst_rvalid", 64'(rvalid_o), 64'(0));
        check("rst_wea", 64'(wea_o), 64'(0));
        check("rst_enb", 64'(enb_o), 64'(0));
        check("rst_rdata", 64'(rdata_o), 64'(0));

        // Preload 0x10/0x20 via contending writes: req0 first, then req1.
        cyc(1, 2'b11, 2'b11, 2'b00, 8'h10, 8'h20, 32'hA0A0_0010, 32'hB1B1_0020, 2'b01, 0, 0);
        cyc(1, 2'b10, 2'b11, 2'b00, 8'h10, 8'h20, 32'hA0A0_0010, 32'hB1B1_0020, 2'b10, 0, 0);

        // Continuous contending reads alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, (i % 2 == 0) ? 2'b01 : 2'b10,
                (i % 2 == 0) ? 32'hA0A0_0010 : 32'hB1B1_0020, 1);
        end

        // Same-address write/read: write first, read deferred one cycle sees new data.
        cyc(1, 2'b11, 2'b01, 2'b00, 8'h05, 8'h05, 32'hDEAD_BEEF, 0, 2'b01, 0, 0);
        cyc(1, 2'b10, 2'b00, 2'b00, 8'h05, 8'h05, 0, 0, 2'b10, 32'hDEAD_BEEF, 1);

        // Different-address write and read both granted together.
        cyc(1, 2'b11, 2'b01, 2'b00, 8'h01, 8'h02, 32'h1, 0, 2'b11, 32'hC0DE_0002, 1);

        // Write pointer now favours req1; then req0 alone; then read back req1's word.
        cyc(1, 2'b11, 2'b11, 2'b00, 8'h07, 8'h08, 32'h7, 32'h8, 2'b10, 0, 0);
        cyc(1, 2'b01, 2'b11, 2'b00, 8'h07, 8'h08, 32'h7, 32'h8, 2'b01, 0, 0);
        cyc(1, 2'b01, 2'b00, 2'b00, 8'h08, 8'h00, 0, 0, 2'b01, 32'h8, 1);

        // Read burst interrupted by reset the cycle after a grant; that read must never return.
        cyc(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b10, 32'hB1B1_0020, 1);
        cyc(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b01, 0, 0);
        cyc(0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        check("rst_mid_rvalid", 64'(rvalid_o), 64'(0));
        cyc(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b01, 32'hA0A0_0010, 1);
        @(negedge clk);
        check("post_rst_rvalid", 64'(rvalid_o), 64'(0));

        // Locked write burst from req0 against a steady req1.
        for (int i = 0; i < 20; i++) begin
`ifdef OFF_MEM_ARB_LOCK_EN
            cyc(1, 2'b11, 2'b11, 2'b01, 8'h30, 8'h31, 32'(i), 32'(100 + i),
                (i == 16) ? 2'b10 : 2'b01, 0, 0);
`else
            cyc(1, 2'b11, 2'b11, 2'b01, 8'h30, 8'h31, 32'(i), 32'(100 + i),
                (i % 2 == 0) ? 2'b01 : 2'b10, 0, 0);
`endif
        end

        cyc(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 0);
        cyc(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 0);
        repeat (2) @(negedge clk);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));
        check("cyc_queue_drained", 64'(cyc_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
